// File: rtl/root_access_ctrl.sv
// Root-side access controller: packs host writes/read requests into credit-controlled flits for
// the root router LOCAL port and buffers returning read responses for the host.
module root_access_ctrl #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned CREDIT_DEPTH = 4,
    parameter int unsigned RSP_DEPTH    = 4,
    localparam int unsigned FLIT_W      = 2 + ADDR_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic              write_rdy,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    output logic              read_rdy,
    output logic              read_data_vld,
    output logic [DATA_W-1:0] read_data,
    input  logic              read_data_rdy,
    output logic              out_data_valid,
    output logic [FLIT_W-1:0] out_data,
    input  logic              downstream_credit,
    input  logic              in_data_valid,
    input  logic [FLIT_W-1:0] in_data,
    output logic              upstream_credit,
    output logic              err
);

    localparam int unsigned CW = $clog2(CREDIT_DEPTH + 1);
    localparam int unsigned OW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PW = $clog2(RSP_DEPTH);

    localparam logic [1:0] TypeWrite   = 2'b01;
    localparam logic [1:0] TypeReadReq = 2'b10;
    localparam logic [1:0] TypeReadRsp = 2'b11;

    localparam logic [CW-1:0] CreditMax = CW'(CREDIT_DEPTH);
    localparam logic [OW-1:0] RspMax    = OW'(RSP_DEPTH);

    typedef enum logic {PriWrite, PriRead} pri_e;

    pri_e              pri_q, pri_d;
    logic [CW-1:0]     credit_q, credit_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic [OW-1:0]     count_q, count_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DATA_W-1:0] mem [RSP_DEPTH];
    logic              out_valid_q;
    logic [FLIT_W-1:0] out_flit_q, flit_d;
    logic              upc_q;
    logic              err_q, err_d;

    logic w_ok, r_ok, grant_w, grant_r, issue;
    logic pop, push, rsp_valid, unsolicited, credit_sat, credit_inc;
    logic [1:0] in_type;

    assign in_type     = in_data[FLIT_W-1 -: 2];
    assign rsp_valid   = in_data_valid && (in_type == TypeReadRsp);
    // Every buffered or in-flight response belongs to an outstanding read; none left means rogue.
    assign unsolicited = (count_q == outst_q);
    assign push        = rsp_valid && !unsolicited;
    assign pop         = (count_q != '0) && read_data_rdy;
    assign credit_sat  = downstream_credit && (credit_q == CreditMax);
    assign credit_inc  = downstream_credit && !credit_sat;

    // rst gates the grants so nothing is reported accepted while reset is asserted.
    assign w_ok = rst && write_en && (credit_q != '0);
    assign r_ok = rst && read_en && (credit_q != '0) && (outst_q < RspMax);

    always_comb begin
        pri_d   = pri_q;
        grant_w = w_ok && (!r_ok || pri_q == PriWrite);
        grant_r = r_ok && (!w_ok || pri_q == PriRead);
        if (w_ok && r_ok) begin
            pri_d = (pri_q == PriWrite) ? PriRead : PriWrite;
        end
    end

    assign issue = grant_w || grant_r;

    always_comb begin
        credit_d = credit_q;
        unique case ({issue, credit_inc})
            2'b10:   credit_d = credit_q - CW'(1);
            2'b01:   credit_d = credit_q + CW'(1);
            default: credit_d = credit_q;
        endcase

        outst_d = outst_q;
        unique case ({grant_r, pop})
            2'b10:   outst_d = outst_q + OW'(1);
            2'b01:   outst_d = outst_q - OW'(1);
            default: outst_d = outst_q;
        endcase

        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + OW'(1);
            2'b01:   count_d = count_q - OW'(1);
            default: count_d = count_q;
        endcase

        flit_d = grant_w ? {TypeWrite, write_addr, write_data}
                         : {TypeReadReq, read_addr, {DATA_W{1'b0}}};

        err_d = err_q || credit_sat || (rsp_valid && unsolicited)
                || (in_data_valid && in_type != TypeReadRsp);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pri_q       <= PriWrite;
            credit_q    <= CreditMax;
            outst_q     <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            upc_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pri_q       <= pri_d;
            credit_q    <= credit_d;
            outst_q     <= outst_d;
            count_q     <= count_d;
            out_valid_q <= issue;
            upc_q       <= pop;
            err_q       <= err_d;
            if (issue) begin
                out_flit_q <= flit_d;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Response storage needs no reset; validity comes from count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data[DATA_W-1:0];
        end
    end

    assign write_rdy       = grant_w;
    assign read_rdy        = grant_r;
    assign read_data_vld   = (count_q != '0);
    assign read_data       = mem[rd_ptr_q];
    assign out_data_valid  = out_valid_q;
    assign out_data        = out_flit_q;
    assign upstream_credit = upc_q;
    assign err             = err_q;

endmodule
